// File: rtl/usb_pkg.sv
// usb_pkg: shared USB receive-path types and constants.
// Used by usb_nrzi_decoder and bit_unstuffer.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2,
    ERR   = 2'd3
  } rx_dec_state_t;

  localparam int USB_MAX_ONES = 6;

  // Width of a counter that must hold 0..max_ones inclusive.
  function automatic int ones_cnt_width(input int max_ones);
    return $clog2(max_ones + 1);
  endfunction

endpackage

// File: rtl/usb_nrzi_decoder_if.sv
// usb_nrzi_decoder_if: serial line input and decoded bit output of the NRZI receiver.
// master drives the line side; slave is the decoder.
interface usb_nrzi_decoder_if;

  logic in_bit;
  logic in_valid;
  logic out_bit;
  logic out_valid;
  logic rx_active;
  logic stuff_err;

  modport master (
    output in_bit,
    output in_valid,
    input  out_bit,
    input  out_valid,
    input  rx_active,
    input  stuff_err
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    output out_bit,
    output out_valid,
    output rx_active,
    output stuff_err
  );

endinterface

// File: rtl/bit_unstuffer.sv
// bit_unstuffer: packet FSM, run-of-ones tracking and stuff-bit removal on the decoded stream.
// Build option USB_RX_UNSTUFF_EN: when undefined only IDLE/DATA tracking is built and err_o is 0.
module bit_unstuffer
  import usb_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_i,
  input  logic valid_i,
  output logic first_o,
  output logic valid_o,
  output logic active_o,
  output logic err_o
);

  if (MAX_ONES < 1) begin : g_max_ones_check
    $error("bit_unstuffer: MAX_ONES must be at least 1");
  end

  rx_dec_state_t state_q;
  logic          valid_q;
  logic          active_q;

  assign first_o  = (state_q == IDLE);
  assign valid_o  = valid_q;
  assign active_o = active_q;

`ifdef USB_RX_UNSTUFF_EN

  localparam int CW = ones_cnt_width(MAX_ONES);

  logic [CW-1:0] ones_q;
  logic          err_q;

  assign err_o = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            valid_q  <= 1'b1;
            active_q <= 1'b1;
            ones_q   <= CW'(bit_i);
            state_q  <= (MAX_ONES == 1 && bit_i) ? STUFF : DATA;
          end
        end
        DATA: begin
          if (!valid_i) begin
            ones_q  <= '0;
            state_q <= IDLE;
          end else begin
            valid_q  <= 1'b1;
            active_q <= 1'b1;
            if (!bit_i) begin
              ones_q <= '0;
            end else begin
              if (ones_q != CW'(MAX_ONES)) begin
                ones_q <= ones_q + CW'(1);
              end
              if (int'(ones_q) + 1 >= MAX_ONES) begin
                state_q <= STUFF;
              end
            end
          end
        end
        STUFF: begin
          // End of packet here abandons the pending stuff slot silently.
          if (!valid_i) begin
            ones_q  <= '0;
            state_q <= IDLE;
          end else if (!bit_i) begin
            active_q <= 1'b1;
            ones_q   <= '0;
            state_q  <= DATA;
          end else begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end
        end
        ERR: begin
          if (!valid_i) begin
            ones_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          ones_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`else

  logic unused_bit;
  assign unused_bit = bit_i;
  assign err_o      = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      valid_q  <= valid_i;
      active_q <= valid_i;
      state_q  <= valid_i ? DATA : IDLE;
    end
  end

`endif

endmodule

// File: rtl/usb_nrzi_decoder.sv
// usb_nrzi_decoder: USB receive NRZI decoder; one line bit per clock, one-cycle registered latency.
// Build option USB_RX_UNSTUFF_EN enables stuff-bit removal and stuffing-violation reporting.
module usb_nrzi_decoder
  import usb_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES
) (
  input  logic              clock,
  input  logic              reset_n,
  usb_nrzi_decoder_if.slave rx
);

  logic prev_line_q;
  logic out_bit_q;
  logic first_bit;
  logic decoded;
  logic out_valid;
  logic rx_active;
  logic stuff_err;

  // The first bit of a packet has no reference level, so it passes through raw.
  assign decoded = first_bit ? rx.in_bit : (rx.in_bit ~^ prev_line_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_line_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      prev_line_q <= rx.in_valid ? rx.in_bit : 1'b0;
      out_bit_q   <= rx.in_valid & decoded;
    end
  end

  bit_unstuffer #(
    .MAX_ONES(MAX_ONES)
  ) u_unstuffer (
    .clock    (clock),
    .reset_n  (reset_n),
    .bit_i    (decoded),
    .valid_i  (rx.in_valid),
    .first_o  (first_bit),
    .valid_o  (out_valid),
    .active_o (rx_active),
    .err_o    (stuff_err)
  );

  assign rx.out_bit   = out_bit_q;
  assign rx.out_valid = out_valid;
  assign rx.rx_active = rx_active;
  assign rx.stuff_err = stuff_err;

endmodule

// File: tb/tb_usb_nrzi_decoder.sv
// tb_usb_nrzi_decoder: directed vector table plus reset and round-trip sequences.
// Expectations follow the USB_RX_UNSTUFF_EN build option when it is defined.
module tb_usb_nrzi_decoder;

  typedef struct {
    logic in_bit;
    logic in_valid;
    logic exp_valid;
    logic exp_bit;
    logic exp_active;
    logic exp_err;
  } vec_t;

`ifdef USB_RX_UNSTUFF_EN
  localparam logic U = 1'b1;
`else
  localparam logic U = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;
  vec_t vecs[$];

  usb_nrzi_decoder_if bus ();

  usb_nrzi_decoder #(
    .MAX_ONES(6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ib, input logic iv, input logic ev,
                              input logic eb, input logic ea, input logic ee);
    vec_t v;
    v.in_bit     = ib;
    v.in_valid   = iv;
    v.exp_valid  = ev;
    v.exp_bit    = eb;
    v.exp_active = ea;
    v.exp_err    = ee;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    bus.in_bit   = v.in_bit;
    bus.in_valid = v.in_valid;
    @(posedge clock);
    #1;
    chk({tag, ".out_valid"}, bus.out_valid, v.exp_valid);
    if (v.exp_valid) chk({tag, ".out_bit"}, bus.out_bit, v.exp_bit);
    chk({tag, ".rx_active"}, bus.rx_active, v.exp_active);
    chk({tag, ".stuff_err"}, bus.stuff_err, v.exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".out_bit"},   bus.out_bit,   1'b0);
    chk({tag, ".out_valid"}, bus.out_valid, 1'b0);
    chk({tag, ".rx_active"}, bus.rx_active, 1'b0);
    chk({tag, ".stuff_err"}, bus.stuff_err, 1'b0);
  endtask

  initial begin
    logic [23:0] rt_data;
    logic [23:0] rt_line;

    n_pass       = 0;
    n_total      = 0;
    reset_n      = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;

    // basic decode: line 0,1,1,0 -> 0,0,1,0
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    // five ones then a zero: no stuff slot
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    // legal stuff: line 1x6,0,0
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, !U, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    // violation: line held at 1 for 8 cycles
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, !U, 1, !U, U));
    vecs.push_back(mk(1, 1, !U, 1, !U, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    // abort inside the stuff slot, then a new packet starting with line 0
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));

    #12;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // round trip through an NRZI encoder model (first bit raw, 1 = no transition)
    rt_data = 24'b00001_0100_0000101_11100001;
    rt_line[0] = rt_data[0];
    for (int i = 1; i < 24; i++) begin
      rt_line[i] = rt_data[i] ? rt_line[i-1] : ~rt_line[i-1];
    end
    for (int i = 0; i < 24; i++) begin
      step(mk(rt_line[i], 1, 1, rt_data[i], 1, 0), $sformatf("rt%0d", i));
    end
    step(mk(0, 0, 0, 0, 0, 0), "rt_end");

    // reset mid-packet; afterwards the first bit (1) must pass through raw
    step(mk(0, 1, 1, 0, 1, 0), "rst_a");
    step(mk(0, 1, 1, 1, 1, 0), "rst_b");
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clock);
    #1;
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    step(mk(1, 1, 1, 1, 1, 0), "rst_first");
    step(mk(0, 1, 1, 0, 1, 0), "rst_second");
    step(mk(0, 0, 0, 0, 0, 0), "rst_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
